// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: buffers read/write commands in a small FIFO and runs them one at a
// time as single AHB transfers with a pulse-select handshake and a response timeout.
module ahb_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic        hready,
    output logic [31:0] hwdata,
    input  logic        hreadyout,
    input  logic [31:0] hrdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [64:0]   mem_q [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hsel_q, hsel_d, hready_q, hready_d, hwrite_q, hwrite_d;
    logic [31:0]   haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [64:0]   head;
    logic          full, empty, push, pop, timed_out;

    assign head      = mem_q[rd_ptr_q[PW-1:0]];
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // gated by hresetn so the requester sees not-ready for the whole reset window
    assign cmd_ready = hresetn && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = !empty && (state_q == IDLE || state_q == RESP);
    assign busy      = state_q != IDLE || !empty;
    assign timed_out = cnt_q == CW'(TIMEOUT - 1);

    assign hsel      = hsel_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hready    = hready_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (PW+1)'(pop);
        state_d     = state_q;
        cnt_d       = cnt_q;
        hsel_d      = 1'b0;
        hready_d    = 1'b0;
        haddr_d     = pop ? head[63:32] : haddr_q;
        hwrite_d    = pop ? head[64]    : hwrite_q;
        hwdata_d    = pop ? head[31:0]  : hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE, RESP: begin
                state_d  = pop ? ADDR : IDLE;
                hsel_d   = pop;
                hready_d = pop;
            end
            ADDR: begin
                state_d  = WAIT;
                cnt_d    = '0;
                hready_d = 1'b1;
            end
            default: begin
                if (hreadyout || timed_out) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !hreadyout;
                    rsp_rdata_d = (hreadyout && !hwrite_q) ? hrdata : '0;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    hready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hsel_q      <= 1'b0;
            hready_q    <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hsel_q      <= hsel_d;
            hready_q    <= hready_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed bench driving ahb_cmd_master against a 32-word
// pulse-select slave model that can optionally stall.
module tb_ahb_cmd_master;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, busy, hsel, hwrite, hready;
    logic [31:0] rsp_rdata, haddr, hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    int errors = 0, checks = 0, cyc = 0;
    int hsel_cnt = 0, last_hsel_cyc = -1;
    logic prev_hsel = 1'b0, in_xfer = 1'b0;
    logic [64:0] cap;
    int          rq_cyc [$];
    logic [31:0] rq_data [$];
    logic        rq_err [$];

    logic        stall = 1'b0;
    logic [1:0]  ph;
    logic [4:0]  sa;
    logic [31:0] smem [32];

    ahb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
        .hreadyout(hreadyout), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    // slave: T1 latch address, T2 write/load, T3 hreadyout pulse
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ph <= 2'd0;
            hreadyout <= 1'b0;
            hrdata <= '0;
            sa <= '0;
        end else begin
            case (ph)
                2'd0: if (hsel && !stall) ph <= 2'd1;
                2'd1: begin sa <= haddr[4:0]; ph <= 2'd2; end
                2'd2: begin
                    if (hwrite) smem[sa] <= hwdata;
                    else hrdata <= smem[sa];
                    hreadyout <= 1'b1;
                    ph <= 2'd3;
                end
                default: begin hreadyout <= 1'b0; ph <= 2'd0; end
            endcase
        end
    end

    // advance to the next sample point and apply the always-on protocol checks
    task automatic step();
        @(negedge hclk);
        cyc++;
        if (hresetn) begin
            checks++;
            if (hsel && prev_hsel) begin errors++; $display("FAIL hsel_double: hsel high two cycles at cyc %0d", cyc); end
            if (in_xfer && !hsel) begin
                checks++;
                if ({hwrite, haddr, hwdata} !== cap) begin
                    errors++;
                    $display("FAIL bus_hold: got %h expected %h at cyc %0d", {hwrite, haddr, hwdata}, cap, cyc);
                end
            end
            if (!rsp_valid) begin
                checks++;
                if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_idle: rdata=%h err=%b expected 0/0 at cyc %0d", rsp_rdata, rsp_err, cyc);
                end
            end
            if (hsel) begin
                cap = {hwrite, haddr, hwdata};
                in_xfer = 1'b1;
                hsel_cnt++;
                last_hsel_cyc = cyc;
            end else if (hreadyout || rsp_valid) in_xfer = 1'b0;
            if (rsp_valid) begin rq_cyc.push_back(cyc); rq_data.push_back(rsp_rdata); rq_err.push_back(rsp_err); end
            prev_hsel = hsel;
        end else begin
            in_xfer = 1'b0;
            prev_hsel = 1'b0;
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        acc = -1;
        for (int n = 0; n < 50 && acc < 0; n++) begin
            if (cmd_ready) acc = cyc;
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc < 0) begin errors++; $display("FAIL push_accept: addr %h not accepted within 50 cycles", a); end
    endtask

    task automatic wait_rsp(output int c, output logic [31:0] d, output logic e);
        for (int n = 0; n < 100 && rq_cyc.size() == 0; n++) step();
        checks++;
        if (rq_cyc.size() == 0) begin
            errors++; $display("FAIL rsp_wait: no response within 100 cycles");
            c = -1; d = 'x; e = 1'bx;
        end else begin
            c = rq_cyc.pop_front(); d = rq_data.pop_front(); e = rq_err.pop_front();
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        step(); step();
        checks++;
        if ({cmd_ready, busy, hsel, hready, rsp_valid, rsp_err, hwrite} !== 7'b0 || {haddr, hwdata, rsp_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_outputs: cmd_ready=%b busy=%b hsel=%b hready=%b rsp_valid=%b expected all 0", cmd_ready, busy, hsel, hready, rsp_valid);
        end
        hresetn = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if ({hsel, hready, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
                errors++; $display("FAIL idle_quiet: hsel/hready/rsp_valid/busy/cmd_ready=%b expected 00001", {hsel, hready, rsp_valid, busy, cmd_ready});
            end
        end
    endtask

    task automatic test_write_read();
        int acc, c, h0;
        logic [31:0] d;
        logic e;
        h0 = hsel_cnt;
        push_cmd(1'b1, 32'h5, 32'hDEADBEEF, acc);
        wait_rsp(c, d, e);
        checks++;
        if (last_hsel_cyc !== acc + 2 || hsel_cnt !== h0 + 1) begin
            errors++; $display("FAIL wr_hsel: hsel at %0d count %0d expected at %0d count %0d", last_hsel_cyc, hsel_cnt - h0, acc + 2, 1);
        end
        checks++;
        if (c !== acc + 6 || d !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: cyc %0d rdata %h err %b expected cyc %0d rdata 0 err 0", c, d, e, acc + 6);
        end
        checks++;
        if (smem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h expected deadbeef", smem[5]); end
        push_cmd(1'b0, 32'h5, 32'h0, acc);
        wait_rsp(c, d, e);
        checks++;
        if (c !== acc + 6 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: cyc %0d rdata %h err %b expected cyc %0d rdata deadbeef err 0", c, d, e, acc + 6);
        end
    endtask

    task automatic test_back_to_back();
        logic        w [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] a [6] = '{32'h1, 32'h2, 32'h3, 32'h1, 32'h2, 32'h3};
        logic [31:0] wd [6] = '{32'h11111111, 32'h22220002, 32'hA5A55A5A, 32'h0, 32'h0, 32'h0};
        logic [31:0] exp_d [6] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22220002, 32'hA5A55A5A};
        int acc [6];
        int c, first;
        logic [31:0] d;
        logic e;
        for (int i = 0; i < 5; i++) push_cmd(w[i], a[i], wd[i], acc[i]);
        checks++;
        if (acc[4] !== acc[0] + 4 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL fifo_full: acc4 %0d cmd_ready %b busy %b expected %0d/0/1", acc[4], cmd_ready, busy, acc[0] + 4);
        end
        push_cmd(w[5], a[5], wd[5], acc[5]);
        checks++;
        if (acc[5] !== acc[0] + 7) begin errors++; $display("FAIL fifo_refill: accepted %0d expected %0d", acc[5], acc[0] + 7); end
        first = acc[0] + 6;
        for (int i = 0; i < 6; i++) begin
            wait_rsp(c, d, e);
            checks++;
            if (c !== first + 5 * i || d !== exp_d[i] || e !== 1'b0) begin
                errors++; $display("FAIL b2b_rsp%0d: cyc %0d rdata %h err %b expected cyc %0d rdata %h err 0", i, c, d, e, first + 5 * i, exp_d[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int acc, c, h;
        logic [31:0] d;
        logic e;
        stall = 1'b1;
        push_cmd(1'b0, 32'h7, 32'h0, acc);
        wait_rsp(c, d, e);
        h = last_hsel_cyc;
        checks++;
        if (h !== acc + 2 || c !== h + 17 || d !== 32'h0 || e !== 1'b1 || hready !== 1'b0) begin
            errors++; $display("FAIL timeout_rsp: hsel %0d rsp %0d rdata %h err %b hready %b expected %0d %0d 0 1 0", h, c, d, e, hready, acc + 2, acc + 19);
        end
        stall = 1'b0;
        push_cmd(1'b1, 32'h9, 32'h0BADF00D, acc);
        wait_rsp(c, d, e);
        checks++;
        if (last_hsel_cyc !== acc + 2 || c !== acc + 6 || e !== 1'b0 || smem[9] !== 32'h0BADF00D) begin
            errors++; $display("FAIL after_timeout: hsel %0d rsp %0d err %b mem %h expected %0d %0d 0 0badf00d", last_hsel_cyc, c, e, smem[9], acc + 2, acc + 6);
        end
    endtask

    task automatic test_reset_mid();
        int acc0, acc1, acc2, h, r;
        push_cmd(1'b0, 32'h1, 32'h0, acc0);
        push_cmd(1'b1, 32'h2, 32'hFFFF0002, acc1);
        push_cmd(1'b1, 32'h3, 32'hFFFF0003, acc2);
        checks++;
        if (cyc !== acc0 + 3 || hready !== 1'b1 || hsel !== 1'b0 || last_hsel_cyc !== acc0 + 2) begin
            errors++; $display("FAIL mid_setup: cyc %0d hready %b hsel %b expected %0d 1 0 (in WAIT)", cyc, hready, hsel, acc0 + 3);
        end
        h = hsel_cnt;
        r = rq_cyc.size();
        hresetn = 1'b0;
        step();
        checks++;
        if ({cmd_ready, busy, hsel, hready, rsp_valid} !== 5'b0 || haddr !== 32'h0) begin
            errors++; $display("FAIL mid_in_reset: cmd_ready/busy/hsel/hready/rsp_valid=%b haddr %h expected 0", {cmd_ready, busy, hsel, hready, rsp_valid}, haddr);
        end
        step();
        hresetn = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_release: cmd_ready %b busy %b expected 1/0", cmd_ready, busy);
        end
        for (int n = 0; n < 30; n++) step();
        checks++;
        if (hsel_cnt !== h || rq_cyc.size() !== r || busy !== 1'b0 || smem[2] !== 32'h22220002) begin
            errors++; $display("FAIL mid_flush: hsel pulses %0d rsps %0d busy %b mem2 %h expected 0 0 0 22220002", hsel_cnt - h, rq_cyc.size() - r, busy, smem[2]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
